// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction field helpers and the
// writeback data-source decode used by the W stage.
package mips_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_IDX_W = 5;

   localparam logic [5:0] OPC_LW     = 6'h23;
   localparam logic [5:0] OPC_JAL    = 6'h03;
   localparam logic [5:0] OPC_RTYPE  = 6'h00;
   localparam logic [5:0] FUNCT_JALR = 6'h09;

   typedef enum logic [1:0] {
      WSEL_ALU = 2'd0,
      WSEL_MEM = 2'd1,
      WSEL_PC8 = 2'd2
   } wsel_e;

   function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
      return instr[31:26];
   endfunction

   function automatic logic [5:0] instr_funct(input logic [31:0] instr);
      return instr[5:0];
   endfunction

   // Anything not recognised as a load or link falls back to the ALU path.
   function automatic wsel_e decode_wsel(input logic [31:0] instr);
      wsel_e sel;
      sel = WSEL_ALU;
      if (instr_opcode(instr) == OPC_LW) begin
         sel = WSEL_MEM;
      end else if ((instr_opcode(instr) == OPC_JAL) ||
                   ((instr_opcode(instr) == OPC_RTYPE) &&
                    (instr_funct(instr) == FUNCT_JALR))) begin
         sel = WSEL_PC8;
      end
      return sel;
   endfunction

endpackage

// File: rtl/grf_32x32.sv
// General register file: synchronous clear, one write port, two
// combinational read ports with write-first bypass; entry 0 reads as zero.
module grf_32x32 #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we,
   input  logic [$clog2(NREG)-1:0]   waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [$clog2(NREG)-1:0]   raddr_a,
   input  logic [$clog2(NREG)-1:0]   raddr_b,
   output logic [DATA_W-1:0]         rdata_a,
   output logic [DATA_W-1:0]         rdata_b
);
   localparam int IDX_W = $clog2(NREG);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
         if (reset || (i == 0)) begin
            regs_d[i] = '0;
         end else if (we && (waddr == IDX_W'(i))) begin
            regs_d[i] = wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         regs_q[i] <= regs_d[i];
      end
   end

   // The write of the current W instruction is visible to readers this cycle.
   always_comb begin
      rdata_a = regs_q[raddr_a];
      if (raddr_a == '0) begin
         rdata_a = '0;
      end else if (we && (raddr_a == waddr)) begin
         rdata_a = wdata;
      end
   end

   always_comb begin
      rdata_b = regs_q[raddr_b];
      if (raddr_b == '0) begin
         rdata_b = '0;
      end else if (we && (raddr_b == waddr)) begin
         rdata_b = wdata;
      end
   end

endmodule

// File: rtl/w_stage_grf.sv
// MIPS writeback stage: selects the W write data, commits it to the GRF,
// and exports the forwarding value, a commit trace and a retired count.
module w_stage_grf #(
   parameter int DATA_W       = 32,
   parameter int NREG         = 32,
   parameter int RETIRE_CNT_W = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               W_PC,
   input  logic [31:0]               W_inStr,
   input  logic [31:0]               W_PC8,
   input  logic [$clog2(NREG)-1:0]   W_writeReg_NUM,
   input  logic [DATA_W-1:0]         W_dataOUT,
   input  logic [DATA_W-1:0]         W_aluResult,
   input  logic [$clog2(NREG)-1:0]   D_rs_NUM,
   input  logic [$clog2(NREG)-1:0]   D_rt_NUM,
   output logic [DATA_W-1:0]         D_rs_DATA,
   output logic [DATA_W-1:0]         D_rt_DATA,
   output logic [DATA_W-1:0]         W_writeData,
   output logic                      dbg_we,
   output logic [31:0]               dbg_pc,
   output logic [$clog2(NREG)-1:0]   dbg_addr,
   output logic [DATA_W-1:0]         dbg_wdata,
   output logic [RETIRE_CNT_W-1:0]   retired_cnt
);
   import mips_pkg::*;

   wsel_e                   wsel;
   logic                    we;
   logic [RETIRE_CNT_W-1:0] retired_q;
   logic [RETIRE_CNT_W-1:0] retired_d;

   always_comb begin
      wsel = decode_wsel(W_inStr);
      case (wsel)
         WSEL_MEM: W_writeData = W_dataOUT;
         WSEL_PC8: W_writeData = DATA_W'(W_PC8);
         default:  W_writeData = W_aluResult;
      endcase
   end

   // Reset both discards the pending write and disables the read bypass.
   assign we = (W_writeReg_NUM != '0) && !reset;

   grf_32x32 #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_grf (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .waddr   (W_writeReg_NUM),
      .wdata   (W_writeData),
      .raddr_a (D_rs_NUM),
      .raddr_b (D_rt_NUM),
      .rdata_a (D_rs_DATA),
      .rdata_b (D_rt_DATA)
   );

   always_comb begin
      retired_d = retired_q;
      if (reset) begin
         retired_d = '0;
      end else if (W_inStr != 32'd0) begin
         retired_d = retired_q + RETIRE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      retired_q <= retired_d;
   end

   assign retired_cnt = retired_q;
   assign dbg_we      = we;
   assign dbg_pc      = W_PC;
   assign dbg_addr    = W_writeReg_NUM;
   assign dbg_wdata   = W_writeData;

endmodule

// File: tb/tb_w_stage_grf.sv
// Self-checking bench for w_stage_grf: directed scenarios plus randomized
// traffic against a register-array / counter reference model.
module tb_w_stage_grf;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] W_PC, W_inStr, W_PC8, W_dataOUT, W_aluResult;
   logic [4:0]  W_writeReg_NUM, D_rs_NUM, D_rt_NUM;
   logic [31:0] D_rs_DATA, D_rt_DATA, W_writeData, dbg_pc, dbg_wdata, retired_cnt;
   logic        dbg_we;
   logic [4:0]  dbg_addr;
   // narrow-counter instance used to exercise the wrap-around
   logic [31:0] s_rs, s_rt, s_wd, s_pc, s_wdata;
   logic        s_we;
   logic [4:0]  s_addr;
   logic [3:0]  s_cnt;

   logic [31:0] mgrf [32];
   logic [31:0] mcnt;
   logic [3:0]  mcnt_s;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   w_stage_grf dut (
      .clk(clk), .reset(reset), .W_PC(W_PC), .W_inStr(W_inStr), .W_PC8(W_PC8),
      .W_writeReg_NUM(W_writeReg_NUM), .W_dataOUT(W_dataOUT), .W_aluResult(W_aluResult),
      .D_rs_NUM(D_rs_NUM), .D_rt_NUM(D_rt_NUM), .D_rs_DATA(D_rs_DATA), .D_rt_DATA(D_rt_DATA),
      .W_writeData(W_writeData), .dbg_we(dbg_we), .dbg_pc(dbg_pc), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .retired_cnt(retired_cnt)
   );

   w_stage_grf #(.RETIRE_CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .W_PC(W_PC), .W_inStr(W_inStr), .W_PC8(W_PC8),
      .W_writeReg_NUM(W_writeReg_NUM), .W_dataOUT(W_dataOUT), .W_aluResult(W_aluResult),
      .D_rs_NUM(D_rs_NUM), .D_rt_NUM(D_rt_NUM), .D_rs_DATA(s_rs), .D_rt_DATA(s_rt),
      .W_writeData(s_wd), .dbg_we(s_we), .dbg_pc(s_pc), .dbg_addr(s_addr),
      .dbg_wdata(s_wdata), .retired_cnt(s_cnt)
   );

   function automatic logic [31:0] exp_wdata();
      logic [5:0] op, fn;
      op = W_inStr[31:26];
      fn = W_inStr[5:0];
      if (op == 6'h23) return W_dataOUT;
      if (op == 6'h03 || (op == 6'h00 && fn == 6'h09)) return W_PC8;
      return W_aluResult;
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (!reset && W_writeReg_NUM != 5'd0 && idx == W_writeReg_NUM) return exp_wdata();
      return mgrf[idx];
   endfunction

   function automatic logic [31:0] mk_addu();
      return {6'h00, 15'($urandom), 5'h00, 6'h21};
   endfunction

   task automatic drive(input logic [31:0] instr, input logic [4:0] dest,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc8, input logic [4:0] rs, input logic [4:0] rt);
      @(negedge clk);
      W_inStr = instr; W_writeReg_NUM = dest; W_aluResult = alu; W_dataOUT = mem;
      W_PC8 = pc8; W_PC = pc8 - 32'd8; D_rs_NUM = rs; D_rt_NUM = rt;
      #1;
   endtask

   // Advance one rising edge and apply the architectural effect to the model.
   task automatic tick();
      logic [31:0] wd;
      wd = exp_wdata();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) mgrf[i] = 32'd0;
         mcnt = 32'd0;
         mcnt_s = 4'd0;
      end else begin
         if (W_writeReg_NUM != 5'd0) mgrf[W_writeReg_NUM] = wd;
         if (W_inStr != 32'd0) begin
            mcnt = mcnt + 32'd1;
            mcnt_s = mcnt_s + 4'd1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(mk_addu(), 5'd5, 32'h1234, 32'h0, 32'h8, 5'd5, 5'd0);
      checks++;
      if (dbg_we !== 1'b0) begin
         failures++; $display("FAIL reset_dbg_we got=%b exp=0", dbg_we);
      end
      tick();
      drive(mk_addu(), 5'd5, 32'h1234, 32'h0, 32'h8, 5'd5, 5'd5);
      checks++;
      if (D_rs_DATA !== 32'd0 || D_rt_DATA !== 32'd0) begin
         failures++; $display("FAIL reset_read got=%h/%h exp=0", D_rs_DATA, D_rt_DATA);
      end
      tick();
      reset = 1'b0;
      drive(32'd0, 5'd0, 32'h0, 32'h0, 32'h8, 5'd5, 5'd17);
      checks++;
      if (D_rs_DATA !== 32'd0 || D_rt_DATA !== 32'd0 || retired_cnt !== 32'd0) begin
         failures++;
         $display("FAIL reset_state got rs=%h rt=%h cnt=%0d exp 0/0/0", D_rs_DATA, D_rt_DATA, retired_cnt);
      end
      tick();
      $display("test_reset done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_alu_write();
      drive(mk_addu(), 5'd8, 32'hDEADBEEF, 32'h11, 32'h1008, 5'd8, 5'd8);
      checks++;
      if (D_rs_DATA !== 32'hDEADBEEF || D_rt_DATA !== 32'hDEADBEEF || dbg_we !== 1'b1) begin
         failures++;
         $display("FAIL alu_bypass got rs=%h rt=%h we=%b exp=deadbeef we=1", D_rs_DATA, D_rt_DATA, dbg_we);
      end
      checks++;
      if (dbg_addr !== 5'd8 || dbg_wdata !== 32'hDEADBEEF || dbg_pc !== 32'h1000) begin
         failures++;
         $display("FAIL alu_trace got addr=%0d wdata=%h pc=%h exp 8/deadbeef/1000", dbg_addr, dbg_wdata, dbg_pc);
      end
      tick();
      drive(32'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
      checks++;
      if (D_rs_DATA !== 32'hDEADBEEF || D_rt_DATA !== 32'd0) begin
         failures++; $display("FAIL alu_array got rs=%h rt=%h exp=deadbeef/0", D_rs_DATA, D_rt_DATA);
      end
      tick();
      $display("test_alu_write done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_load_link();
      drive({6'h23, 26'h0A90004}, 5'd9, 32'hAAAA, 32'h55, 32'h2008, 5'd0, 5'd9);
      checks++;
      if (W_writeData !== 32'h55) begin
         failures++; $display("FAIL lw_select got=%h exp=55", W_writeData);
      end
      tick();
      drive({6'h03, 26'h0000C00}, 5'd31, 32'hBBBB, 32'hCCCC, 32'h3008, 5'd9, 5'd0);
      checks++;
      if (W_writeData !== 32'h3008 || D_rs_DATA !== 32'h55) begin
         failures++; $display("FAIL jal_select got wd=%h rs9=%h exp=3008/55", W_writeData, D_rs_DATA);
      end
      tick();
      drive({6'h00, 5'd4, 5'd0, 5'd2, 5'd0, 6'h09}, 5'd2, 32'hBBBB, 32'hCCCC, 32'h4010, 5'd31, 5'd2);
      checks++;
      if (W_writeData !== 32'h4010 || D_rs_DATA !== 32'h3008 || D_rt_DATA !== 32'h4010) begin
         failures++;
         $display("FAIL jalr_select got wd=%h rs31=%h rt2=%h exp=4010/3008/4010", W_writeData, D_rs_DATA, D_rt_DATA);
      end
      tick();
      drive(32'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd2, 5'd9);
      checks++;
      if (D_rs_DATA !== 32'h4010 || D_rt_DATA !== 32'h55) begin
         failures++; $display("FAIL link_array got rs2=%h rt9=%h exp=4010/55", D_rs_DATA, D_rt_DATA);
      end
      tick();
      $display("test_load_link done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_zero_guard();
      drive(mk_addu(), 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0);
      checks++;
      if (dbg_we !== 1'b0 || D_rs_DATA !== 32'd0 || D_rt_DATA !== 32'd0) begin
         failures++;
         $display("FAIL zero_guard got we=%b rs=%h rt=%h exp=0/0/0", dbg_we, D_rs_DATA, D_rt_DATA);
      end
      tick();
      drive(32'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8);
      checks++;
      if (D_rs_DATA !== 32'd0 || D_rt_DATA !== 32'hDEADBEEF) begin
         failures++; $display("FAIL zero_after got rs0=%h rt8=%h exp=0/deadbeef", D_rs_DATA, D_rt_DATA);
      end
      tick();
      $display("test_zero_guard done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_counter();
      reset = 1'b1;
      drive(32'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive((i == 1 || i == 3) ? 32'd0 : mk_addu(), 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
         tick();
      end
      drive(32'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      checks++;
      if (retired_cnt !== 32'd3 || s_cnt !== 4'd3) begin
         failures++; $display("FAIL count3 got=%0d small=%0d exp=3", retired_cnt, s_cnt);
      end
      for (int i = 0; i < 13; i++) begin
         drive(mk_addu(), 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
         tick();
      end
      drive(32'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      checks++;
      if (s_cnt !== 4'd0 || retired_cnt !== 32'd16) begin
         failures++; $display("FAIL count_wrap got small=%0d big=%0d exp=0/16", s_cnt, retired_cnt);
      end
      tick();
      $display("test_counter done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_midrun_reset();
      drive(mk_addu(), 5'd4, 32'h77, 32'h0, 32'h0, 5'd0, 5'd0);
      tick();
      reset = 1'b1;
      drive(mk_addu(), 5'd4, 32'h99, 32'h0, 32'h0, 5'd4, 5'd0);
      checks++;
      if (dbg_we !== 1'b0 || D_rs_DATA !== 32'h77) begin
         failures++; $display("FAIL midrst_during got we=%b rs4=%h exp=0/77", dbg_we, D_rs_DATA);
      end
      tick();
      reset = 1'b0;
      drive(mk_addu(), 5'd4, 32'h88, 32'h0, 32'h0, 5'd0, 5'd4);
      checks++;
      if (retired_cnt !== 32'd0 || D_rt_DATA !== 32'h88) begin
         failures++; $display("FAIL midrst_after got cnt=%0d rt4=%h exp=0/88", retired_cnt, D_rt_DATA);
      end
      tick();
      drive(32'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd0);
      checks++;
      if (D_rs_DATA !== 32'h88 || retired_cnt !== 32'd1) begin
         failures++; $display("FAIL midrst_write got rs4=%h cnt=%0d exp=88/1", D_rs_DATA, retired_cnt);
      end
      tick();
      $display("test_midrun_reset done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_random();
      logic [31:0] instr;
      logic [4:0]  dest, rs, rt;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 5))
            0:       instr = 32'd0;
            1:       instr = mk_addu();
            2:       instr = {6'h23, 26'($urandom)};
            3:       instr = {6'h03, 26'($urandom)};
            4:       instr = {6'h00, 20'($urandom), 6'h09};
            default: instr = $urandom;
         endcase
         dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         rs = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom);
         rt = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom);
         reset = ($urandom_range(0, 39) == 0);
         drive(instr, dest, $urandom, $urandom, $urandom, rs, rt);
         checks++;
         if (D_rs_DATA !== exp_read(rs) || D_rt_DATA !== exp_read(rt)) begin
            failures++;
            $display("FAIL rand_read n=%0d got rs=%h rt=%h exp=%h/%h", n, D_rs_DATA, D_rt_DATA, exp_read(rs), exp_read(rt));
         end
         checks++;
         if (W_writeData !== exp_wdata() || dbg_we !== (!reset && dest != 5'd0) || dbg_addr !== dest) begin
            failures++;
            $display("FAIL rand_wsel n=%0d got wd=%h we=%b exp wd=%h", n, W_writeData, dbg_we, exp_wdata());
         end
         checks++;
         if (retired_cnt !== mcnt || s_cnt !== mcnt_s) begin
            failures++;
            $display("FAIL rand_cnt n=%0d got=%0d small=%0d exp=%0d/%0d", n, retired_cnt, s_cnt, mcnt, mcnt_s);
         end
         tick();
      end
      reset = 1'b0;
      $display("test_random done checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      reset = 1'b1;
      W_PC = '0; W_inStr = '0; W_PC8 = '0; W_dataOUT = '0; W_aluResult = '0;
      W_writeReg_NUM = '0; D_rs_NUM = '0; D_rt_NUM = '0;
      mcnt = '0; mcnt_s = '0;
      for (int i = 0; i < 32; i++) mgrf[i] = 32'd0;
      test_reset();
      test_alu_write();
      test_load_link();
      test_zero_guard();
      test_counter();
      test_midrun_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
